// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter: shares one uncached I/O command channel among num_req_p requesters.
// Latency: one arbitration cycle before a command is offered; responses route combinationally.
// Backpressure: grant held until io_cmd_yumi_i; stall at max_credits_p; response held until owner ready. BP_IO_ARB_FIXED_PRIO_EN = fixed priority.

module bp_io_cmd_arbiter_fifo #(
    parameter int width_p = 1,
    parameter int depth_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           push_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           pop_i,
    output logic [width_p-1:0]             data_o,
    output logic                           empty_o,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);
    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);
    localparam logic [ptr_w_lp-1:0] last_lp  = ptr_w_lp'(depth_p - 1);
    localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);

    logic [width_p-1:0]  mem_q [depth_p];
    logic [ptr_w_lp-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                do_push, do_pop;

    assign do_push = push_i && (count_q != depth_lp);
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = (wr_q == last_lp) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == last_lp) ? '0 : rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

module bp_io_cmd_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int max_credits_p = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]   req_cmd_i,
    input  logic [num_req_p-1:0]               req_cmd_v_i,
    output logic [num_req_p-1:0]               req_cmd_yumi_o,
    output logic [msg_width_p-1:0]             io_cmd_o,
    output logic                               io_cmd_v_o,
    input  logic                               io_cmd_yumi_i,
    input  logic [msg_width_p-1:0]             io_resp_i,
    input  logic                               io_resp_v_i,
    output logic                               io_resp_ready_o,
    output logic [msg_width_p-1:0]             req_resp_o,
    output logic [num_req_p-1:0]               req_resp_v_o,
    input  logic [num_req_p-1:0]               req_resp_ready_i,
    input  logic                               drain_i,
    output logic                               drained_o,
    output logic [$clog2(max_credits_p+1)-1:0] credit_count_o
);
    localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w_lp = $clog2(max_credits_p + 1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp  = cnt_w_lp'(max_credits_p);
    localparam logic [id_w_lp-1:0]  last_id_lp  = id_w_lp'(num_req_p - 1);

    typedef enum logic [1:0] {RUN, LOCK, DRAIN, DRAINED} state_e;

    state_e               state_q, state_d;
    logic [id_w_lp-1:0]   grant_q, grant_d, winner, head_id;
    logic [msg_width_p-1:0] cmd_arr [num_req_p];
    logic                 fifo_empty, push, resp_hs;
    logic [cnt_w_lp-1:0]  credit_cnt;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign cmd_arr[g] = req_cmd_i[g*msg_width_p +: msg_width_p];
    end

`ifdef BP_IO_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (req_cmd_v_i[i]) winner = id_w_lp'(i);
        end
    end
`else
    logic [id_w_lp-1:0] ptr_q, ptr_d;

    // Search upward from the pointer, wrapping past the last requester.
    always_comb begin
        logic               found;
        logic [id_w_lp-1:0] cand;
        winner = ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            cand = id_w_lp'((int'(ptr_q) + k) % num_req_p);
            if (!found && req_cmd_v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == LOCK && io_cmd_yumi_i)
            ptr_d = (grant_q == last_id_lp) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        push    = 1'b0;
        case (state_q)
            RUN: begin
                if (drain_i) begin
                    state_d = DRAIN;
                end else if (|req_cmd_v_i && credit_cnt < max_cnt_lp) begin
                    grant_d = winner;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (io_cmd_yumi_i) begin
                    push    = 1'b1;
                    state_d = drain_i ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (!drain_i)                            state_d = RUN;
                else if (credit_cnt == '0 && !resp_hs)   state_d = DRAINED;
            end
            DRAINED: begin
                if (!drain_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // The order FIFO remembers issuers so in-order responses find their owner.
    bp_io_cmd_arbiter_fifo #(
        .width_p (id_w_lp),
        .depth_p (max_credits_p)
    ) order_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .data_i    (grant_q),
        .pop_i     (resp_hs),
        .data_o    (head_id),
        .empty_o   (fifo_empty),
        .count_o   (credit_cnt)
    );

    assign io_cmd_v_o      = (state_q == LOCK);
    assign io_cmd_o        = cmd_arr[grant_q];
    assign drained_o       = (state_q == DRAINED);
    assign credit_count_o  = credit_cnt;
    assign io_resp_ready_o = !fifo_empty && req_resp_ready_i[head_id];
    assign resp_hs         = io_resp_v_i && io_resp_ready_o;
    assign req_resp_o      = io_resp_i;

    always_comb begin
        req_cmd_yumi_o = '0;
        req_resp_v_o   = '0;
        if (state_q == LOCK && io_cmd_yumi_i) req_cmd_yumi_o[grant_q] = 1'b1;
        if (io_resp_v_i && !fifo_empty)       req_resp_v_o[head_id]   = 1'b1;
    end
endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter: 2 requesters, 32-bit messages, 4 credits.
module tb_bp_io_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd0, cmd1;
    logic [63:0] req_cmd;
    logic [1:0]  req_cmd_v, req_cmd_yumi, req_resp_v, req_resp_ready;
    logic [31:0] io_cmd, io_resp, req_resp;
    logic        io_cmd_v, io_cmd_yumi, io_resp_v, io_resp_ready, drain, drained;
    logic [2:0]  credit;

    int checks = 0;
    int errors = 0;

    assign req_cmd = {cmd1, cmd0};

    always #5 clk = ~clk;

    bp_io_cmd_arbiter #(.num_req_p(2), .msg_width_p(32), .max_credits_p(4)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_yumi_o(req_cmd_yumi),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_yumi_i(io_cmd_yumi),
        .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_ready_o(io_resp_ready),
        .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_ready_i(req_resp_ready),
        .drain_i(drain), .drained_o(drained), .credit_count_o(credit)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0; cmd0 = '0; cmd1 = '0; req_cmd_v = '0; io_cmd_yumi = 1'b0;
        io_resp = '0; io_resp_v = 1'b0; req_resp_ready = 2'b11; drain = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (io_cmd_v !== 1'b0 || req_cmd_yumi !== 2'b00 || io_resp_ready !== 1'b0 ||
            req_resp_v !== 2'b00 || drained !== 1'b0 || credit !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b yumi=%b rdy=%b rv=%b drained=%b credit=%0d, expected all 0",
                     io_cmd_v, req_cmd_yumi, io_resp_ready, req_resp_v, drained, credit);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [31:0] q_dat[$];
        int          q_id[$];
        int          q_due[$];
        int          gnt_cnt = 0, rsp_cnt = 0, n0 = 0, n1 = 0, exp_id;
        logic [31:0] exp_cmd;
        logic [1:0]  exp_v;
        bit          issued, answered;
        cmd0 = 32'hA000_0000; cmd1 = 32'hB000_0000;
        req_cmd_v = 2'b11; io_cmd_yumi = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            issued = 0; answered = 0; exp_id = 0;
            if (io_cmd_v) begin
                exp_id  = gnt_cnt % 2;
                exp_cmd = (exp_id == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(gnt_cnt / 2);
                exp_v   = (exp_id == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_cmd_yumi !== exp_v || io_cmd !== exp_cmd) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got yumi=%b cmd=%h, expected yumi=%b cmd=%h",
                             gnt_cnt, req_cmd_yumi, io_cmd, exp_v, exp_cmd);
                end
                q_dat.push_back(exp_cmd); q_id.push_back(exp_id); q_due.push_back(cyc + 2);
                gnt_cnt++;
                issued = 1;
            end
            if (io_resp_v) begin
                exp_v = (q_id[0] == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_resp_v !== exp_v || req_resp !== q_dat[0] || io_resp_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_resp%0d: got rv=%b data=%h rdy=%b, expected rv=%b data=%h rdy=1",
                             rsp_cnt, req_resp_v, req_resp, io_resp_ready, exp_v, q_dat[0]);
                end
                answered = 1;
            end
            @(posedge clk); #1;
            if (issued) begin
                if (exp_id == 0) begin cmd0 = cmd0 + 1; n0++; if (n0 == 4) req_cmd_v[0] = 1'b0; end
                else             begin cmd1 = cmd1 + 1; n1++; if (n1 == 4) req_cmd_v[1] = 1'b0; end
            end
            if (answered) begin
                void'(q_dat.pop_front()); void'(q_id.pop_front()); void'(q_due.pop_front());
                rsp_cnt++;
            end
            io_resp_v = (q_due.size() > 0) && (cyc + 1 >= q_due[0]);
            io_resp   = (q_dat.size() > 0) ? q_dat[0] : 32'h0;
        end
        io_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_cnt != 8 || rsp_cnt != 8 || credit !== 3'd0) begin
            errors++;
            $display("FAIL rr_totals: got grants=%0d resps=%0d credit=%0d, expected 8 8 0",
                     gnt_cnt, rsp_cnt, credit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_credit_limit;
        int g = 0;
        cmd1 = 32'hC100_0000; req_cmd_v = 2'b10; io_cmd_yumi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_cmd_v) begin
                g++;
                checks++;
                if (req_cmd_yumi !== 2'b10) begin
                    errors++;
                    $display("FAIL credit_yumi: got %b, expected 10", req_cmd_yumi);
                end
            end
        end
        checks++;
        if (g != 4 || io_cmd_v !== 1'b0 || credit !== 3'd4) begin
            errors++;
            $display("FAIL credit_full: got grants=%0d v=%b credit=%0d, expected 4 0 4", g, io_cmd_v, credit);
        end
        @(posedge clk); #1;
        io_resp = 32'h5555_0001; io_resp_v = 1'b1;
        @(negedge clk);
        checks++;
        if (io_resp_ready !== 1'b1 || req_resp_v !== 2'b10) begin
            errors++;
            $display("FAIL credit_release: got rdy=%b rv=%b, expected 1 10", io_resp_ready, req_resp_v);
        end
        @(posedge clk); #1;
        io_resp_v = 1'b0;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (io_cmd_v) g++;
        end
        checks++;
        if (g != 1 || credit !== 3'd4) begin
            errors++;
            $display("FAIL credit_one_more: got grants=%0d credit=%0d, expected 1 4", g, credit);
        end
        @(posedge clk); #1;
        req_cmd_v = 2'b00; io_resp_v = 1'b1;
        repeat (4) @(posedge clk);
        #1 io_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (credit !== 3'd0) begin
            errors++;
            $display("FAIL credit_clear: got credit=%0d, expected 0", credit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lock_hold;
        int k;
        cmd0 = 32'hD000_0000; cmd1 = 32'hD111_1111; req_cmd_v = 2'b10; io_cmd_yumi = 1'b0;
        k = 0;
        @(negedge clk);
        while (!io_cmd_v && k < 8) begin @(negedge clk); k++; end
        checks++;
        if (io_cmd_v !== 1'b1) begin
            errors++;
            $display("FAIL lock_grant: io_cmd_v=%b after %0d cycles, expected 1", io_cmd_v, k);
        end
        req_cmd_v = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (io_cmd_v !== 1'b1 || io_cmd !== 32'hD111_1111 || req_cmd_yumi !== 2'b00) begin
                errors++;
                $display("FAIL lock_hold%0d: got v=%b cmd=%h yumi=%b, expected 1 d1111111 00",
                         i, io_cmd_v, io_cmd, req_cmd_yumi);
            end
        end
        io_cmd_yumi = 1'b1;
        #1;
        checks++;
        if (req_cmd_yumi !== 2'b10) begin
            errors++;
            $display("FAIL lock_accept: got yumi=%b, expected 10", req_cmd_yumi);
        end
        @(posedge clk); #1;
        req_cmd_v = 2'b01;
        k = 0;
        @(negedge clk);
        while (!io_cmd_v && k < 8) begin @(negedge clk); k++; end
        checks++;
        if (io_cmd_v !== 1'b1 || io_cmd !== 32'hD000_0000 || req_cmd_yumi !== 2'b01) begin
            errors++;
            $display("FAIL lock_next: got v=%b cmd=%h yumi=%b, expected 1 d0000000 01",
                     io_cmd_v, io_cmd, req_cmd_yumi);
        end
        @(posedge clk); #1;
        req_cmd_v = 2'b00; io_cmd_yumi = 1'b0;
        io_resp = 32'hE100_0001; io_resp_v = 1'b1;
        @(negedge clk);
        checks++;
        if (req_resp_v !== 2'b10 || req_resp !== 32'hE100_0001) begin
            errors++;
            $display("FAIL lock_resp1: got rv=%b data=%h, expected 10 e1000001", req_resp_v, req_resp);
        end
        @(posedge clk); #1;
        io_resp = 32'hE000_0002;
        @(negedge clk);
        checks++;
        if (req_resp_v !== 2'b01 || req_resp !== 32'hE000_0002) begin
            errors++;
            $display("FAIL lock_resp0: got rv=%b data=%h, expected 01 e0000002", req_resp_v, req_resp);
        end
        @(posedge clk); #1;
        io_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (credit !== 3'd0) begin
            errors++;
            $display("FAIL lock_credit: got %0d, expected 0", credit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drain;
        int k;
        cmd0 = 32'hF000_0000; req_cmd_v = 2'b01; io_cmd_yumi = 1'b1;
        k = 0;
        @(negedge clk);
        while (credit !== 3'd3 && k < 20) begin @(negedge clk); k++; end
        drain = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (io_cmd_v !== 1'b0 || drained !== 1'b0 || credit !== 3'd3) begin
                errors++;
                $display("FAIL drain_block%0d: got v=%b drained=%b credit=%0d, expected 0 0 3",
                         i, io_cmd_v, drained, credit);
            end
        end
        @(posedge clk); #1;
        io_resp = 32'h7777_0000; io_resp_v = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (drained !== 1'b0 || credit !== 3'd1 || io_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_last: got drained=%b credit=%0d rdy=%b, expected 0 1 1",
                     drained, credit, io_resp_ready);
        end
        @(posedge clk); #1;
        io_resp_v = 1'b0;
        k = 0;
        @(negedge clk);
        while (!drained && k < 4) begin @(negedge clk); k++; end
        checks++;
        if (drained !== 1'b1 || credit !== 3'd0 || io_cmd_v !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: got drained=%b credit=%0d v=%b, expected 1 0 0", drained, credit, io_cmd_v);
        end
        drain = 1'b0;
        k = 0;
        @(negedge clk);
        while (!io_cmd_v && k < 8) begin @(negedge clk); k++; end
        checks++;
        if (io_cmd_v !== 1'b1 || req_cmd_yumi !== 2'b01 || drained !== 1'b0) begin
            errors++;
            $display("FAIL drain_resume: got v=%b yumi=%b drained=%b, expected 1 01 0",
                     io_cmd_v, req_cmd_yumi, drained);
        end
        @(posedge clk); #1;
        req_cmd_v = 2'b00; io_resp_v = 1'b1;
        @(posedge clk); #1;
        io_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (credit !== 3'd0) begin
            errors++;
            $display("FAIL drain_credit: got %0d, expected 0", credit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_resp_backpressure;
        int k;
        io_resp = 32'h9999_0000; io_resp_v = 1'b1; req_resp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (io_resp_ready !== 1'b0 || req_resp_v !== 2'b00) begin
            errors++;
            $display("FAIL stray_resp: got rdy=%b rv=%b, expected 0 00", io_resp_ready, req_resp_v);
        end
        @(posedge clk); #1;
        req_resp_ready = 2'b10; req_cmd_v = 2'b01; io_cmd_yumi = 1'b1;
        k = 0;
        @(negedge clk);
        while (credit !== 3'd1 && k < 10) begin @(negedge clk); k++; end
        req_cmd_v = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (io_resp_ready !== 1'b0 || req_resp_v !== 2'b01 || credit !== 3'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b rv=%b credit=%0d, expected 0 01 1",
                         i, io_resp_ready, req_resp_v, credit);
            end
        end
        req_resp_ready = 2'b11;
        #1;
        checks++;
        if (io_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b, expected 1", io_resp_ready);
        end
        @(posedge clk); #1;
        io_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (credit !== 3'd0) begin
            errors++;
            $display("FAIL bp_credit: got %0d, expected 0", credit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_lock;
        int k;
        cmd0 = 32'h1234_0000; cmd1 = 32'h1234_1111; req_cmd_v = 2'b01; io_cmd_yumi = 1'b1;
        k = 0;
        @(negedge clk);
        while (credit !== 3'd2 && k < 10) begin @(negedge clk); k++; end
        io_cmd_yumi = 1'b0;
        @(negedge clk);
        checks++;
        if (io_cmd_v !== 1'b1 || credit !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_lock: got v=%b credit=%0d, expected 1 2", io_cmd_v, credit);
        end
        req_cmd_v = 2'b11; io_cmd_yumi = 1'b1; io_resp_v = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (io_cmd_v !== 1'b0 || credit !== 3'd0 || io_resp_ready !== 1'b0 || req_resp_v !== 2'b00 ||
            req_cmd_yumi !== 2'b00 || drained !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b credit=%0d rdy=%b rv=%b yumi=%b drained=%b, expected all 0",
                     io_cmd_v, credit, io_resp_ready, req_resp_v, req_cmd_yumi, drained);
        end
        @(negedge clk);
        rst_n = 1'b1; io_resp_v = 1'b0;
        k = 0;
        @(negedge clk);
        while (!io_cmd_v && k < 8) begin @(negedge clk); k++; end
        checks++;
        if (io_cmd_v !== 1'b1 || req_cmd_yumi !== 2'b01 || io_cmd !== 32'h1234_0000) begin
            errors++;
            $display("FAIL post_reset_grant: got v=%b yumi=%b cmd=%h, expected 1 01 12340000",
                     io_cmd_v, req_cmd_yumi, io_cmd);
        end
        @(posedge clk); #1;
        req_cmd_v = 2'b00; io_cmd_yumi = 1'b0;
        @(negedge clk);
        checks++;
        if (credit !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_credit: got %0d, expected 1", credit);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_lock_hold();
        test_drain();
        test_resp_backpressure();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
- Shares one uncached I/O command channel (io_cmd/io_resp, cce_mem_msg format) among num_req_p requesters, e.g. the NBF loader, host bridge and debug module.
- Round-robin grant, locked until the channel accepts the command.
- Credit-limited outstanding commands; in-order responses steered back to their issuer via an order FIFO.
- drain_i stops new grants and waits for all responses, so software/bench can quiesce the channel before freeze release.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- msg_width_p, 128, width of one cce_mem_msg; set to cce_mem_msg_width_lp at instantiation.
- max_credits_p, 16, maximum outstanding commands; equals order FIFO depth; power of two not required.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous and active-low.
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command; requester i occupies slice [i*msg_width_p +: msg_width_p].
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  one-hot; command consumed this cycle.
- io_cmd_o  out  msg_width_p  granted command.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  channel consumed the command.
- io_resp_i  in  msg_width_p  response.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  arbiter can route the response.
- req_resp_o  out  msg_width_p  io_resp_i broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot response valid, owner only.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- drain_i  in  1  level; block new grants while high.
- drained_o  out  1  drain complete, zero outstanding.
- credit_count_o  out  clog2(max_credits_p+1)  outstanding commands.

Behaviour:
- Reset (reset_n_i low, async): state RUN, grant register 0, round-robin pointer 0, FIFO empty, credit count 0. All outputs 0 except io_cmd_o, which is don't-care with io_cmd_v_o=0.
- State RUN:
  - If drain_i=1, go to DRAIN.
  - Otherwise, if any req_cmd_v_i and credits < max_credits_p, register the round-robin winner, searching upward from pointer with wrap at num_req_p-1 to 0.
  - Go to LOCK. Arbitration costs one cycle; no command is offered in RUN.
- State LOCK:
  - io_cmd_v_o=1, io_cmd_o = slice of the granted requester.
  - Grant is held until io_cmd_yumi_i. The requester must keep valid and data stable; dropping valid is illegal.
  - On io_cmd_yumi_i:
    - req_cmd_yumi_o[grant]=1 in the same cycle (combinational).
    - Push the grant id into the order FIFO; credit +1.
    - Pointer becomes grant+1 mod num_req_p.
    - Go to RUN, or to DRAIN if drain_i=1.
- State DRAIN: no grants. When credit count = 0 and no response handshake is in progress, go to DRAINED.
- State DRAINED: drained_o=1. When drain_i=0, go to RUN.
  - drain_i falling in DRAIN returns to RUN immediately.
- Response path, independent of state:
  - Head = order FIFO head. io_resp_ready_o = FIFO non-empty AND req_resp_ready_i[head].
  - req_resp_v_o[head] = io_resp_v_i AND FIFO non-empty.
  - Handshake = io_resp_v_i AND io_resp_ready_o; it pops the FIFO and decrements credit.
- Simultaneous push and pop in one cycle: credit unchanged, FIFO occupancy unchanged.
- Full: io_cmd_v_o never asserts with credit = max_credits_p; a grant is not taken in RUN when full.
- Empty FIFO: io_resp_ready_o=0; a stray response is held off indefinitely, never dropped or misrouted.
- credit_count_o = FIFO occupancy, registered.

Optional Feature:
- Macro BP_IO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the round-robin pointer is removed.
- Undefined (default): round-robin as described above.

Test Plan:
- Reqs 0 and 1 both valid continuously, yumi always 1, responses 2 cycles later -> grants 0,1,0,1; each requester sees exactly its own responses in order.
- max_credits_p=4, responses withheld -> 4 commands issued; io_cmd_v_o stays 0 and credit_count_o=4. Release 1 response -> exactly one more grant.
- Grant to req 1, io_cmd_yumi_i held low 10 cycles -> io_cmd_v_o=1 with stable data; no switch to req 0 even though req 0 is valid.
- 3 outstanding, drain_i=1 -> no new grants; drained_o=1 one cycle after the 3rd response. Deassert drain_i -> arbitration resumes.
- Response for req 0 while req_resp_ready_i[0]=0 -> io_resp_ready_o=0, FIFO head and credit unchanged until ready rises.
- reset_n_i pulsed low mid-LOCK with 2 outstanding -> all outputs 0 immediately (async), credit_count_o=0, pointer 0; first grant after reset goes to req 0.
